// File: rtl/operand_fetch_stage_pkg.sv
// operand_fetch_stage_pkg
//   Shared constants for the operand fetch stage:
//   - default operand width and register-address width
//   - register count, which is also the scoreboard width
//   - bit positions of the fixed 16-bit instruction fields
//     opcode[15:12] rd[11:9] rs1[8:6] rs2[5:3] imm[2:0]
package operand_fetch_stage_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;
   localparam int NUM_REGS   = 8;

   localparam int INSTR_W = 16;
   localparam int FIELD_W = 3;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 9;
   localparam int RS1_MSB = 8;
   localparam int RS1_LSB = 6;
   localparam int RS2_MSB = 5;
   localparam int RS2_LSB = 3;
   localparam int IMM_MSB = 2;
   localparam int IMM_LSB = 0;

endpackage

// File: rtl/operand_fetch_stage_operand_select.sv
// operand_select
//   Produces one source operand together with its hazard flag.
//   Build option: OPERAND_FETCH_FWD_EN compiles in the same-cycle writeback
//   bypass; without it the operand always comes from the register file and
//   any pending source is reported as a hazard.
// Ports
//   rs_addr  : source register address
//   pending  : scoreboard, one bit per register awaiting writeback
//   rf_data  : combinational register-file read data for rs_addr
//   wb_valid, wb_addr, wb_data : writeback happening this cycle
//   operand  : selected operand value
//   hazard   : source is pending and not covered by the bypass
module operand_select
   import operand_fetch_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0]   rs_addr,
   input  logic [NUM_REGS-1:0] pending,
   input  logic [DATA_W-1:0]   rf_data,
   input  logic                wb_valid,
   input  logic [ADDR_W-1:0]   wb_addr,
   input  logic [DATA_W-1:0]   wb_data,
   output logic [DATA_W-1:0]   operand,
   output logic                hazard
);

`ifdef OPERAND_FETCH_FWD_EN
   logic bypass;

   always_comb begin
      bypass  = wb_valid && (wb_addr == rs_addr);
      operand = bypass ? wb_data : rf_data;
      hazard  = pending[rs_addr] && !bypass;
   end
`else
   // Writeback inputs are only meaningful when the bypass is built in.
   logic unused_wb;

   always_comb begin
      operand   = rf_data;
      hazard    = pending[rs_addr];
      unused_wb = ^{wb_valid, wb_addr, wb_data};
   end
`endif

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   Decodes source registers, reads the register file, tracks outstanding
//   writes in a scoreboard and stalls dependent instructions. Accepted
//   instructions land in a single output register one cycle later.
//   Build option: OPERAND_FETCH_FWD_EN enables same-cycle writeback bypass.
// Ports
//   CLK, Reset            : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake
//   in_instr, in_wr       : instruction word, instruction writes rd
//   rf_addr1/2, rf_data1/2: register-file read ports
//   wb_valid/addr/data    : writeback, clears the scoreboard bit
//   flush                 : squash output register and scoreboard
//   out_valid/out_ready   : downstream handshake
//   out_op/rd/wr/a/b/imm  : issued instruction fields and operands
module operand_fetch_stage
   import operand_fetch_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               in_wr,
   output logic [ADDR_W-1:0]  rf_addr1,
   output logic [ADDR_W-1:0]  rf_addr2,
   input  logic [DATA_W-1:0]  rf_data1,
   input  logic [DATA_W-1:0]  rf_data2,
   input  logic               wb_valid,
   input  logic [ADDR_W-1:0]  wb_addr,
   input  logic [DATA_W-1:0]  wb_data,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3:0]         out_op,
   output logic [ADDR_W-1:0]  out_rd,
   output logic               out_wr,
   output logic [DATA_W-1:0]  out_a,
   output logic [DATA_W-1:0]  out_b,
   output logic [DATA_W-1:0]  out_imm
);

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic                out_valid_q, out_valid_d;
   logic                out_wr_q, out_wr_d;
   logic [3:0]          out_op_q, out_op_d;
   logic [ADDR_W-1:0]   out_rd_q, out_rd_d;
   logic [DATA_W-1:0]   out_a_q, out_a_d;
   logic [DATA_W-1:0]   out_b_q, out_b_d;
   logic [DATA_W-1:0]   out_imm_q, out_imm_d;
   // Low through reset and until the first edge afterwards, so in_ready
   // cannot rise while the block is held in reset.
   logic                ready_en_q, ready_en_d;

   logic [ADDR_W-1:0]   rd_addr;
   logic [FIELD_W-1:0]  imm;
   logic [DATA_W-1:0]   opnd1, opnd2;
   logic                haz1, haz2;
   logic                hazard;
   logic                xfer;

   always_comb begin
      rf_addr1 = ADDR_W'(in_instr[RS1_MSB:RS1_LSB]);
      rf_addr2 = ADDR_W'(in_instr[RS2_MSB:RS2_LSB]);
      rd_addr  = ADDR_W'(in_instr[RD_MSB:RD_LSB]);
      imm      = in_instr[IMM_MSB:IMM_LSB];
   end

   operand_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sel1 (
      .rs_addr  (rf_addr1),
      .pending  (pending_q),
      .rf_data  (rf_data1),
      .wb_valid (wb_valid),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .operand  (opnd1),
      .hazard   (haz1)
   );

   operand_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sel2 (
      .rs_addr  (rf_addr2),
      .pending  (pending_q),
      .rf_data  (rf_data2),
      .wb_valid (wb_valid),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .operand  (opnd2),
      .hazard   (haz2)
   );

   always_comb begin
      hazard   = in_valid && (haz1 || haz2);
      in_ready = ready_en_q && !hazard && (!out_valid_q || out_ready) && !flush;
      xfer     = in_valid && in_ready;
   end

   always_comb begin
      pending_d   = pending_q;
      out_valid_d = out_valid_q;
      out_wr_d    = out_wr_q;
      out_op_d    = out_op_q;
      out_rd_d    = out_rd_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_imm_d   = out_imm_q;
      ready_en_d  = 1'b1;

      if (flush) begin
         pending_d   = '0;
         out_valid_d = 1'b0;
      end else begin
         // Clear first so a same-address set in this cycle wins.
         if (wb_valid) pending_d[wb_addr] = 1'b0;
         if (xfer && in_wr) pending_d[rd_addr] = 1'b1;

         if (xfer) begin
            out_valid_d = 1'b1;
            out_op_d    = in_instr[OP_MSB:OP_LSB];
            out_rd_d    = rd_addr;
            out_wr_d    = in_wr;
            out_a_d     = opnd1;
            out_b_d     = opnd2;
            out_imm_d   = {{(DATA_W-FIELD_W){imm[FIELD_W-1]}}, imm};
         end else if (out_ready) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         pending_q   <= '0;
         out_valid_q <= 1'b0;
         out_wr_q    <= 1'b0;
         out_op_q    <= '0;
         out_rd_q    <= '0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_imm_q   <= '0;
         ready_en_q  <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         out_wr_q    <= out_wr_d;
         out_op_q    <= out_op_d;
         out_rd_q    <= out_rd_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         out_imm_q   <= out_imm_d;
         ready_en_q  <= ready_en_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_wr    = out_wr_q;
   assign out_op    = out_op_q;
   assign out_rd    = out_rd_q;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_imm   = out_imm_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

`ifdef OPERAND_FETCH_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        CLK;
   logic        Reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic        in_wr;
   logic [2:0]  rf_addr1, rf_addr2;
   logic [15:0] rf_data1, rf_data2;
   logic        wb_valid;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_op;
   logic [2:0]  out_rd;
   logic        out_wr;
   logic [15:0] out_a, out_b, out_imm;

   operand_fetch_stage #(.DATA_W(16), .ADDR_W(3)) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_wr     (in_wr),
      .rf_addr1  (rf_addr1),
      .rf_addr2  (rf_addr2),
      .rf_data1  (rf_data1),
      .rf_data2  (rf_data2),
      .wb_valid  (wb_valid),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_op    (out_op),
      .out_rd    (out_rd),
      .out_wr    (out_wr),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_imm   (out_imm)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Register file contents: r[i] = 0xA000 + i*0x0101
   logic [15:0] rf_mem [8];
   initial for (int i = 0; i < 8; i++) rf_mem[i] = 16'hA000 + 16'(i) * 16'h0101;
   always_comb begin
      rf_data1 = rf_mem[rf_addr1];
      rf_data2 = rf_mem[rf_addr2];
   end

   typedef struct {
      logic [3:0]  op;
      logic [2:0]  rd;
      logic        wr;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] imm;
   } exp_t;

   typedef struct {
      logic        v;
      logic [15:0] ins;
      logic        wr;
      logic        wbv;
      logic [2:0]  wba;
      logic [15:0] wbd;
      logic        ordy;
      logic        fl;
      logic        rdy;
   } vec_t;

   exp_t       sb[$];
   logic [7:0] mp;
   logic       mov;
   int         checks = 0;
   int         errors = 0;
   vec_t       tbl[10];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock cycle: drive, check combinational and registered outputs
   // before the edge, advance the bench model, check scoreboard after it.
   task automatic cycle(input logic v, input logic [15:0] ins, input logic wr,
                        input logic wbv, input logic [2:0] wba, input logic [15:0] wbd,
                        input logic ordy, input logic fl, input logic exp_rdy);
      exp_t       e;
      logic       acc;
      logic [2:0] s1, s2, d;
      in_valid = v; in_instr = ins; in_wr = wr;
      wb_valid = wbv; wb_addr = wba; wb_data = wbd;
      out_ready = ordy; flush = fl;
      #2;
      s1 = ins[8:6]; s2 = ins[5:3]; d = ins[11:9];
      chk("in_ready", {15'd0, in_ready}, {15'd0, exp_rdy});
      chk("rf_addr1", {13'd0, rf_addr1}, {13'd0, s1});
      chk("rf_addr2", {13'd0, rf_addr2}, {13'd0, s2});
      chk("out_valid", {15'd0, out_valid}, {15'd0, mov});
      if (mov) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty actual=out_valid expected=no_output at %0t", $time);
         end else begin
            e = sb[0];
            chk("out_op", {12'd0, out_op}, {12'd0, e.op});
            chk("out_rd", {13'd0, out_rd}, {13'd0, e.rd});
            chk("out_wr", {15'd0, out_wr}, {15'd0, e.wr});
            chk("out_a", out_a, e.a);
            chk("out_b", out_b, e.b);
            chk("out_imm", out_imm, e.imm);
            if (ordy || fl) e = sb.pop_front();
         end
      end
      if (fl) sb.delete();
      acc = v && exp_rdy;
      if (acc) begin
         e.op  = ins[15:12];
         e.rd  = d;
         e.wr  = wr;
         e.a   = (FWD && wbv && wba == s1) ? wbd : rf_mem[s1];
         e.b   = (FWD && wbv && wba == s2) ? wbd : rf_mem[s2];
         e.imm = {{13{ins[2]}}, ins[2:0]};
         sb.push_back(e);
      end
      if (fl) mp = '0;
      else begin
         if (wbv) mp[wba] = 1'b0;
         if (acc && wr) mp[d] = 1'b1;
      end
      if (fl) mov = 1'b0;
      else if (acc) mov = 1'b1;
      else if (ordy) mov = 1'b0;
      @(posedge CLK); #1;
      chk("pending", {8'd0, dut.pending_q}, {8'd0, mp});
   endtask

   task automatic chk_reset_outputs();
      chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
      chk("rst_out_wr", {15'd0, out_wr}, 16'd0);
      chk("rst_out_op", {12'd0, out_op}, 16'd0);
      chk("rst_out_rd", {13'd0, out_rd}, 16'd0);
      chk("rst_out_a", out_a, 16'd0);
      chk("rst_out_b", out_b, 16'd0);
      chk("rst_out_imm", out_imm, 16'd0);
      chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
      chk("rst_pending", {8'd0, dut.pending_q}, 16'd0);
   endtask

   initial begin
      // instr = op<<12 | rd<<9 | rs1<<6 | rs2<<3 | imm
      tbl[0] = '{1'b1, 16'h1250, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1};     // basic read r1,r2
      tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1};     // drain
      tbl[2] = '{1'b1, 16'h2607, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1};     // write r3, imm=-1
      tbl[3] = '{1'b1, 16'h38CB, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0};     // read r3: stall
      tbl[4] = tbl[3];
      tbl[5] = tbl[3];
      tbl[6] = tbl[3];
      tbl[7] = '{1'b1, 16'h38CB, 1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b1, 1'b0, FWD};      // wb r3 same cycle
      tbl[8] = '{!FWD, 16'h38CB, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1};     // issue after wb
      tbl[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1};     // drain

      mp = '0; mov = 1'b0;
      Reset = 1'b0;
      in_valid = 1'b1; in_instr = 16'h1250; in_wr = 1'b1;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      out_ready = 1'b1; flush = 1'b0;
      #3;
      chk_reset_outputs();
      #4 Reset = 1'b1;
      #1;
      chk("ready_before_first_edge", {15'd0, in_ready}, 16'd0);
      @(posedge CLK); #1;

      for (int i = 0; i < 10; i++)
         cycle(tbl[i].v, tbl[i].ins, tbl[i].wr, tbl[i].wbv, tbl[i].wba, tbl[i].wbd,
               tbl[i].ordy, tbl[i].fl, tbl[i].rdy);

      // Backpressure: hold output for 5 cycles, then release
      cycle(1'b1, 16'h752D, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 16'h81C1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 16'h81C1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b1);

      // Set and clear of r5 in the same cycle: set wins
      cycle(1'b1, 16'h9A00, 1'b1, 1'b1, 3'd5, 16'h1234, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 16'h0000, 1'b0, 1'b1, 3'd5, 16'h0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 16'h0000, 1'b0, 1'b1, 3'd2, 16'h0, 1'b1, 1'b0, 1'b1);

      // Build pending = 0x0A, then flush with out_valid high
      cycle(1'b1, 16'hA200, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 16'hB600, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 16'hC000, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b1);

      // Reset asserted mid-stall
      cycle(1'b1, 16'h5C02, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 16'h6FB4, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 16'h6FB4, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);
      Reset = 1'b0;
      #1;
      chk_reset_outputs();
      mp = '0; mov = 1'b0; sb.delete();
      #2 Reset = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("ready_after_midreset", {15'd0, in_ready}, 16'd0);
      @(posedge CLK); #1;
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 16'h6FB4, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_fetch_stage.md
OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, operand/data width.
REQ-002 The block SHALL have parameter ADDR_W, default 3, register address width (8 registers).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the following upstream ports: in_valid, input, 1; in_ready, output, 1; in_instr, input, 16 (opcode[15:12], rd[11:9], rs1[8:6], rs2[5:3], imm[2:0]); in_wr, input, 1 (instruction writes rd).
REQ-006 The block SHALL have the following register-file ports: rf_addr1 and rf_addr2, output, ADDR_W each; rf_data1 and rf_data2, input, DATA_W each (combinational read data).
REQ-007 The block SHALL have the following writeback ports: wb_valid, input, 1; wb_addr, input, ADDR_W; wb_data, input, DATA_W.
REQ-008 The block SHALL have port flush, input, 1: squash the output register and clear the scoreboard.
REQ-009 The block SHALL have the following downstream ports: out_valid, output, 1; out_ready, input, 1; out_op, output, 4; out_rd, output, ADDR_W; out_wr, output, 1; out_a, output, DATA_W; out_b, output, DATA_W; out_imm, output, DATA_W.

Function
REQ-010 rf_addr1 and rf_addr2 SHALL be driven combinationally from in_instr[8:6] and in_instr[5:3] respectively.
REQ-011 The block SHALL hold an 8-bit scoreboard, pending[7:0], with one bit per register marking an issued write that has not yet been written back.
REQ-012 A hazard SHALL exist when in_valid is high and pending[rs1] or pending[rs2] is set, and that source is not bypassed by REQ-019.
REQ-013 in_ready SHALL equal !hazard && (!out_valid || out_ready) && !flush.
REQ-014 On a transfer (in_valid && in_ready), the output register SHALL load on the same edge: out_op=instr[15:12], out_rd=rd, out_wr=in_wr, out_a/out_b=selected operands, out_imm=imm sign-extended to DATA_W, and out_valid=1.
REQ-015 When out_valid && out_ready is true with no new transfer, out_valid SHALL clear; output data SHALL be held while out_valid && !out_ready.
REQ-016 A transfer with in_wr=1 SHALL set pending[rd]; wb_valid SHALL clear pending[wb_addr].
REQ-017 When the set and the clear of REQ-016 hit the same address in the same cycle, the set SHALL win.
REQ-018 flush SHALL clear out_valid and all pending bits on the next edge, with no transfer accepted that cycle; flush SHALL take priority over every other event.
REQ-019 When a wb write and a read of the same register occur in the same cycle, the selected operand SHALL be wb_data when FWD_EN is defined; otherwise the hazard of REQ-012 SHALL hold for that cycle.
REQ-020 Total latency SHALL be one cycle from an accepted in_instr to out_valid.

Reset
REQ-021 While Reset=0, asynchronously: out_valid=0, out_wr=0, out_op/out_rd/out_a/out_b/out_imm=0, pending=0.
REQ-022 in_ready SHALL be 0 during reset and SHALL be permitted high from the first edge after Reset deasserts.
REQ-023 A reset asserted mid-stall SHALL discard the stalled state; no instruction SHALL be replayed.

Configuration
REQ-024 Macro OPERAND_FETCH_FWD_EN: when defined, the same-cycle writeback bypass of REQ-019 SHALL be compiled in; when undefined, no bypass SHALL exist and a dependent instruction SHALL issue one cycle after the wb_valid that clears its pending bit, reading the register file.

Structure
REQ-025 A shared package SHALL hold the instruction field positions, DATA_W/ADDR_W defaults, and the register count constant (8).
REQ-026 One sub-module, operand_select, SHALL implement the bypass/select for a single source operand and SHALL be instantiated twice.

Verification
REQ-027 Reset, then issue instr 0x1250 (rd=1, rs1=1, rs2=2) with in_wr=0 -> out_valid=1 next cycle, out_a=rf_data1, out_b=rf_data2.
REQ-028 Issue a write to r3, then an instruction reading r3, with no wb -> in_ready=0 for that instruction, stalling indefinitely.
REQ-029 With r3 pending, in the same cycle drive wb_valid=1, wb_addr=3, wb_data=0xBEEF and present the r3 reader -> with FWD_EN: accepted, out_a=0xBEEF; without FWD_EN: accepted the next cycle.
REQ-030 Hold out_ready=0 with out_valid=1 for 5 cycles -> outputs stable and in_ready=0; release -> next instruction loads.
REQ-031 Issue a write to r5 and a wb clear of r5 in the same cycle -> pending[5] remains 1.
REQ-032 Assert flush with out_valid=1 and pending=0x0A -> next cycle out_valid=0 and pending=0; assert Reset low mid-stall -> all outputs 0 immediately.
